conv_mac_scheduler: RTL
=======================

# conv_mac_scheduler

Round-robin scheduler that shares one multiply-accumulate unit among NREQ requesters, each submitting 3x3 pixel windows for convolution. For a granted window it sequences the 9 taps through the single MAC, one tap per cycle, then presents the signed result with the requester ID on a valid/ready output. The 3x3 kernel is a writable register file; its reset contents are the edge-detect kernel. The block sits between the window generators and the result collector, replacing per-requester convolution engines.

## Interface
- NREQ, 2, number of requesters (2..4)
- PW, 8, pixel width; pixels are unsigned
- ACCW, 32, accumulator/result width; signed
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request i has a window pending
- req_window  in  NREQ*9*PW  window of requester i in bits [i*9*PW +: 9*PW]; pixel k in [k*PW +: PW], k=0..8 row-major
- req_ready  out  NREQ  one-hot grant; handshake on valid&ready
- cfg_we  in  1  kernel coefficient write strobe
- cfg_addr  in  4  coefficient index 0..8; 9..15 ignored
- cfg_data  in  8  signed coefficient
- cfg_ready  out  1  high in IDLE only; writes with cfg_ready low are dropped
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  ACCW  signed convolution result; forced to 0 while out_valid=0
- out_id  out  2  index of the requester that owns out_data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: winner = first i with req_valid[i] set, searching from rr_ptr upward with wrap-around. req_ready[winner]=1 combinationally; all other bits 0. If no requester is valid, req_ready=0.
- Handshake edge in IDLE: latch the winner's 9 pixels and its ID, clear acc, tap=0, rr_ptr <= (winner+1) mod NREQ, go to RUN.
- RUN: each edge does acc <= acc + sext({1'b0,pixel[tap]} * kernel[tap]), with a 9-bit signed x 8-bit signed product sign-extended to ACCW, then tap <= tap+1. The edge with tap=8 moves to DONE.
- DONE: out_valid=1, out_data=acc, out_id=latched ID. When out_valid&out_ready, go to IDLE. No new window is accepted in RUN or DONE.
- Kernel writes: when cfg_we&cfg_ready and cfg_addr<=8, kernel[cfg_addr] <= cfg_data. A write and a grant in the same IDLE cycle are both performed, and the window uses the new coefficient.
- Kernel reset value: {1,1,1,1,-8,1,1,1,1}.
- Requesters hold req_valid and req_window stable until granted. Windows are latched, so they may change after the handshake.
- Reset, including reset mid-RUN or mid-DONE: state=IDLE, acc=0, tap=0, rr_ptr=0, kernel=default. The in-flight window is discarded with no output.

## Timing
- Output reset values: req_ready=0, cfg_ready=1, out_valid=0, out_data=0, out_id=0, busy=0.
- Handshake on edge E0. Taps 0..8 accumulate on edges E1..E9. out_valid is high starting the cycle after E9.
- Minimum interval between successive grants is 11 cycles: 1 IDLE + 9 RUN + 1 DONE with out_ready=1.
- out_ready held low: out_valid, out_data and out_id stay constant, and busy stays 1.
- out_valid&out_ready edge: the next cycle is IDLE, and a pending request is granted in that cycle.
- busy=1 from the cycle after E0 until the cycle after the output handshake.

## Test plan
- Requester 0 submits all pixels 10 with the default kernel -> out_data=0, out_id=0, out_valid first high 10 cycles after the req_valid edge.
- Requester 1 submits center=100, others 0 -> out_data=-800 (0xFFFFFCE0), out_id=1.
- Both requesters continuously valid (req0 all 255 center 0, req1 all 1) -> grant order 0,1,0,1. Results 2040 and 0 alternate, each accepted 11 cycles apart with out_ready=1.
- Write cfg addr4=1 in IDLE, then a window of all 255 -> 2295. A cfg write during RUN is dropped, so the next window still uses the written kernel.
- out_ready low for 5 cycles in DONE while req0 is valid -> out_data held, req_ready stays 0. Grant occurs the cycle after out_ready rises.
- rst pulsed at tap 4 of RUN -> out_valid never rises for that window, busy=0, the kernel returns to default, and the next all-10 window gives 0.

Source files
------------

// File: rtl/conv_mac_scheduler_if.sv
// Request, kernel-config and result bus between window generators,
// the shared-MAC scheduler and the result collector.
interface conv_mac_scheduler_if #(
    parameter int NREQ = 2,
    parameter int PW   = 8,
    parameter int ACCW = 32
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*9*PW-1:0] req_window;
    logic [NREQ-1:0]      req_ready;
    logic                 cfg_we;
    logic [3:0]           cfg_addr;
    logic [7:0]           cfg_data;
    logic                 cfg_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACCW-1:0]      out_data;
    logic [1:0]           out_id;
    logic                 busy;

    // Requester/config/consumer side
    modport master (
        output req_valid, req_window, cfg_we, cfg_addr, cfg_data, out_ready,
        input  req_ready, cfg_ready, out_valid, out_data, out_id, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_window, cfg_we, cfg_addr, cfg_data, out_ready,
        output req_ready, cfg_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/conv_mac_scheduler.sv
// Round-robin scheduler feeding 3x3 windows through one shared MAC,
// one tap per cycle, with a writable 3x3 signed kernel.
module conv_mac_scheduler #(
    parameter int NREQ = 2,
    parameter int PW   = 8,
    parameter int ACCW = 32
) (
    input logic                  clk,
    input logic                  rst,
    conv_mac_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [7:0] KDEF [9] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd8,
                                               8'sd1, 8'sd1, 8'sd1, 8'sd1};

    state_t                 state_q, state_d;
    logic [PW-1:0]          pix_q [9];
    logic [PW-1:0]          pix_d [9];
    logic signed [7:0]      kern_q [9];
    logic signed [7:0]      kern_d [9];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [3:0]             tap_q, tap_d;
    logic [1:0]             rr_q, rr_d;
    logic [1:0]             id_q, id_d;
    logic [1:0]             winner;
    logic                   found;
    logic                   grant;
    logic signed [PW+8:0]   prod;
    int                     idx;

    // Round-robin search: first valid requester at or after rr_q, wrapping
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = 2'(idx);
            end
        end
    end

    assign grant = (state_q == IDLE) && found;

    // One-hot ready only toward the current winner, only while idle
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            bus.req_ready[i] = grant && (winner == 2'(i));
    end

    // Zero-extended pixel times signed coefficient for the current tap
    always_comb prod = $signed({1'b0, pix_q[tap_q]}) * kern_q[tap_q];

    // Next-state: kernel writes, grant latch, tap sequencing, result hold
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tap_d   = tap_q;
        rr_d    = rr_q;
        id_d    = id_q;
        pix_d   = pix_q;
        kern_d  = kern_q;
        if (state_q == IDLE && bus.cfg_we && bus.cfg_addr <= 4'd8)
            kern_d[bus.cfg_addr] = bus.cfg_data;
        case (state_q)
            IDLE: if (grant) begin
                for (int k = 0; k < 9; k++)
                    pix_d[k] = bus.req_window[int'(winner)*9*PW + k*PW +: PW];
                id_d    = winner;
                acc_d   = '0;
                tap_d   = '0;
                rr_d    = (int'(winner) == NREQ-1) ? 2'd0 : winner + 2'd1;
                state_d = RUN;
            end
            RUN: begin
                acc_d = acc_q + ACCW'(prod);
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd8) state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tap_q   <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            for (int k = 0; k < 9; k++) begin
                pix_q[k]  <= '0;
                kern_q[k] <= KDEF[k];
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tap_q   <= tap_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            pix_q   <= pix_d;
            kern_q  <= kern_d;
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = (state_q == DONE) ? acc_q : '0;
    assign bus.out_id    = id_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
